rd_stream_fwft: RTL
===================

// Module: rd_stream_fwft
// PURPOSE
//  Read-side front end of the async FIFO: owns the read pointer, gray conversion and empty/level
//  flags in the rclk domain, drives the registered dual-port RAM read port, and presents words
//  on a first-word-fall-through valid/ready stream through a 2-entry output buffer.
//  Sits between the wptr->rclk 2-FF synchroniser, the FIFO RAM and the downstream consumer.
// PARAMETERS
//  ADDRSIZE  4  RAM address width; depth = 2**ADDRSIZE, pointers are ADDRSIZE+1 bits
//  DATASIZE  8  word width
// PORTS
//  rclk       in   1           read clock
//  rrst_n     in   1           reset, asynchronous, active-low
//  rq2_wptr   in   ADDRSIZE+1  gray write pointer, already synchronised into rclk
//  rptr       out  ADDRSIZE+1  registered gray read pointer (to rclk->wclk synchroniser)
//  raddr      out  ADDRSIZE    RAM read address (binary)
//  ren        out  1           RAM read enable; rdata_mem valid the cycle after
//  rdata_mem  in   DATASIZE    RAM read data (RAM output registered, 1-cycle latency)
//  rempty     out  1           no unfetched words remain in RAM
//  rlevel     out  ADDRSIZE+1  unfetched words in RAM (excludes output buffer)
//  m_valid    out  1           m_data holds a word
//  m_ready    in   1           consumer accepts; pop = m_valid & m_ready
//  m_data     out  DATASIZE    head word, driven from a register
// BEHAVIOUR
//  - Reset: rbin=0, rptr=0, raddr=0, rempty=1, rlevel=0, ren=0, m_valid=0, m_data=0, buffer
//    count=0, inflight=0. Reset mid-stream drops buffered and in-flight words; write side is
//    reset in the same event.
//  - slots = 2 - cnt - inflight + pop (0..2). ren = ~rempty & (slots != 0), combinational.
//  - rbinnext = rbin + ren; rgraynext = (rbinnext>>1)^rbinnext; {rbin,rptr} <= {rbinnext,rgraynext}.
//  - rempty <= (rgraynext == rq2_wptr); raddr = rbin[ADDRSIZE-1:0].
//  - rlevel <= gray2bin(rq2_wptr) - rbinnext, modulo 2**(ADDRSIZE+1).
//  - inflight <= ren. When inflight=1, rdata_mem is written into the buffer that cycle.
//  - Buffer: head/tail regs, cnt 0..2, m_valid = (cnt != 0), m_data = head.
//    pop only: tail->head, cnt-1. push only: into head if cnt=0 (or cnt=1 and popping), else tail.
//    Push and pop together: cnt unchanged, order preserved.
//  - Invariant cnt + inflight <= 2; never overflows, never drops, strict FIFO order.
//  - Latency: rq2_wptr change at edge 0 -> rempty low after edge 1 -> ren -> RAM reg edge 2 ->
//    buffer capture edge 3 -> m_valid high after edge 3.
//  - Throughput: 1 word/cycle sustained when m_ready=1 and RAM non-empty.
//    Full buffer with pop: new ren in the same cycle.
//  - Wrap: rbin wraps 2**(ADDRSIZE+1)-1 -> 0; the MSB/gray difference keeps full-depth (16)
//    distinct from empty.
//  - m_valid/m_data stable while m_valid & ~m_ready.
// STRUCTURE
//  - async_fifo_pkg: functions bin2gray(), gray2bin() for width ADDRSIZE+1; shared by the
//    write-side pointer block.
//  - Sub-module rd_skid2: 2-entry buffer (push, data_in, pop -> valid, data_out, cnt).
//  - Top: pointer/flag regs, slot/ren logic, inflight flag.
// TESTING  (ADDRSIZE=4, DATASIZE=8, RAM model has 1-cycle registered read)
//  1. Reset asserted mid-burst -> next cycle rptr=0, raddr=0, rempty=1, m_valid=0, rlevel=0,
//     ren=0; no stale word after release.
//  2. rq2_wptr=gray(3)=5'b00010, m_ready=1, RAM[0..2]=A0,A1,A2 -> ren 3 consecutive cycles
//     (raddr 0,1,2); m_valid after edge 3 for 3 cycles with A0,A1,A2; final rptr=5'b00010,
//     rempty=1.
//  3. 5 words available, m_ready=0 -> exactly 2 ren pulses, rbin=2, rlevel=3, m_data=word0
//     stable. Raise m_ready -> 5 words in order with no bubble.
//  4. Wrap: stream 40 words in steady flow -> rptr 5'b01000->5'b11000 at 15->16, raddr 15->0,
//     no false rempty, data intact.
//  5. cnt=2, inflight=0, m_ready=1, RAM non-empty -> ren high in the same cycle as the pop;
//     cnt stays 2 next-next cycle.
//  6. Random m_ready (50%) with random rq2_wptr growth -> scoreboard order match; cnt+inflight
//     never exceeds 2; rlevel equals the reference count every cycle.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer blocks (read and write side).
// Gray/binary conversion is width-agnostic: callers zero-extend in and truncate out.
package async_fifo_pkg;

   localparam int GRAY_FN_W = 32;

   typedef logic [GRAY_FN_W-1:0] gray_word_t;

   // Encoding of {push, pop} presented to the 2-entry output buffer.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } skid_op_e;

   function automatic gray_word_t bin2gray(input gray_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Leading zeros in the extended input leave the low bits of the result exact.
   function automatic gray_word_t gray2bin(input gray_word_t g);
      gray_word_t b;
      b = '0;
      for (int i = 0; i < GRAY_FN_W; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/rd_skid2.sv
// Two-entry FIFO buffer feeding the first-word-fall-through stream.
// Head is the presented word; tail holds the next one. Caller never pushes into a full buffer.
module rd_skid2
   import async_fifo_pkg::*;
#(
   parameter int DATASIZE = 8
) (
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic                push_i,
   input  logic [DATASIZE-1:0] data_i,
   input  logic                pop_i,
   output logic                valid_o,
   output logic [DATASIZE-1:0] data_o,
   output logic [1:0]          cnt_o
);

   logic [DATASIZE-1:0] head_q, head_d;
   logic [DATASIZE-1:0] tail_q, tail_d;
   logic [1:0]          cnt_q, cnt_d;
   skid_op_e            op;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      op     = skid_op_e'({push_i, pop_i});
      case (op)
         OP_PUSH: begin
            if (cnt_q == 2'd0) head_d = data_i;
            else               tail_d = data_i;
            cnt_d = cnt_q + 2'd1;
         end
         OP_POP: begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
         end
         OP_BOTH: begin
            // With one entry the incoming word becomes head directly; with two it queues behind.
            if (cnt_q == 2'd1) begin
               head_d = data_i;
            end else begin
               head_d = tail_q;
               tail_d = data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   assign valid_o = (cnt_q != 2'd0);
   assign data_o  = head_q;
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/rd_stream_fwft.sv
// Read-side front end of the async FIFO: read pointer, empty/level flags, RAM read port
// and a first-word-fall-through valid/ready output through a 2-entry buffer.
module rd_stream_fwft
   import async_fifo_pkg::*;
#(
   parameter int ADDRSIZE = 4,
   parameter int DATASIZE = 8
) (
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic [ADDRSIZE:0]   rq2_wptr,
   output logic [ADDRSIZE:0]   rptr,
   output logic [ADDRSIZE-1:0] raddr,
   output logic                ren,
   input  logic [DATASIZE-1:0] rdata_mem,
   output logic                rempty,
   output logic [ADDRSIZE:0]   rlevel,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [DATASIZE-1:0] m_data,
   output logic [1:0]          dbg_cnt_o,
   output logic                dbg_inflight_o
);

   localparam int PW = ADDRSIZE + 1;

   // Stream handshake: a word moves when m_valid & m_ready on a rising rclk edge;
   // m_valid never drops and m_data never changes while m_valid & ~m_ready.

   logic [PW-1:0] rbin_q, rbin_d;
   logic [PW-1:0] rptr_q, rgray_d;
   logic [PW-1:0] rlevel_q, rlevel_d;
   logic          rempty_q, rempty_d;
   logic          inflight_q;
   logic [1:0]    cnt;
   logic          pop;
   logic [2:0]    slots;

   assign pop = m_valid & m_ready;

   // Free buffer places once in-flight words land; only fetch when one is guaranteed.
   assign slots = 3'd2 - {1'b0, cnt} - {2'b0, inflight_q} + {2'b0, pop};
   assign ren   = ~rempty_q & (slots != 3'd0);

   assign rbin_d   = rbin_q + PW'(ren);
   assign rgray_d  = PW'(bin2gray(gray_word_t'(rbin_d)));
   assign rempty_d = (rgray_d == rq2_wptr);
   assign rlevel_d = PW'(gray2bin(gray_word_t'(rq2_wptr))) - rbin_d;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin_q     <= '0;
         rptr_q     <= '0;
         rempty_q   <= 1'b1;
         rlevel_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         rbin_q     <= rbin_d;
         rptr_q     <= rgray_d;
         rempty_q   <= rempty_d;
         rlevel_q   <= rlevel_d;
         inflight_q <= ren;
      end
   end

   // A word read last cycle is on rdata_mem now and goes straight into the buffer.
   rd_skid2 #(
      .DATASIZE (DATASIZE)
   ) u_skid (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .push_i  (inflight_q),
      .data_i  (rdata_mem),
      .pop_i   (pop),
      .valid_o (m_valid),
      .data_o  (m_data),
      .cnt_o   (cnt)
   );

   assign rptr           = rptr_q;
   assign raddr          = rbin_q[ADDRSIZE-1:0];
   assign rempty         = rempty_q;
   assign rlevel         = rlevel_q;
   assign dbg_cnt_o      = cnt;
   assign dbg_inflight_o = inflight_q;

endmodule
